// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first payload,
// optional parity, stop bit; one bit per I_CLK cycle.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  I_CLK,
  input  logic                  RST_EN,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  parity;
  logic                  accept;
  logic                  tx_nxt;
  logic                  busy_nxt;

  // New frames are taken only when the line is idle or finishing
  assign accept = DATA_VALID &&
                  (state == IDLE || state == STOP);

  // Parity always derives from the latched payload
  assign parity = (^data_q) ^ par_typ_q;

  // State, counter, latched frame and registered line outputs
  always_ff @(posedge I_CLK or negedge RST_EN) begin
    if (!RST_EN) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      TX_OUT <= tx_nxt;
      BUSY   <= busy_nxt;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  // Frame sequencing and data bit counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        state_nxt = DATA;
      end
      DATA: begin
        if (cnt == LAST) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
        state_nxt = accept ? START : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line level and busy flag for the upcoming bit period
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b0;
    unique case (state_nxt)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
      START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt   = data_q[cnt_nxt];
        busy_nxt = 1'b1;
      end
      PARITY: begin
        tx_nxt   = parity;
        busy_nxt = 1'b1;
      end
      STOP: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule
